// File: rtl/dcache_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dcache_arbiter                                              |
// | Purpose  : Shares the single-port data cache between the load/store    |
// |            unit (requester 0) and the debug/DMA port (requester 1).    |
// |            Round-robin grant with a lock for atomic sequences, range   |
// |            check with error responses, read data routed to its owner.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module dcache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic                    req0_lock,
  input  logic [ADDR_WIDTH-1:0]   req0_address,
  input  logic [DATA_WIDTH/8-1:0] req0_byte_enable,
  input  logic [DATA_WIDTH-1:0]   req0_write_data,
  output logic                    req0_ready,
  output logic                    rsp0_valid,
  output logic                    rsp0_error,
  output logic [DATA_WIDTH-1:0]   rsp0_read_data,

  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic                    req1_lock,
  input  logic [ADDR_WIDTH-1:0]   req1_address,
  input  logic [DATA_WIDTH/8-1:0] req1_byte_enable,
  input  logic [DATA_WIDTH-1:0]   req1_write_data,
  output logic                    req1_ready,
  output logic                    rsp1_valid,
  output logic                    rsp1_error,
  output logic [DATA_WIDTH-1:0]   rsp1_read_data,

  output logic                    mem_enable,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  // Last byte address of the cache, widened by one bit so that the
  // end-of-word computation can never wrap back into range.
  localparam logic [ADDR_WIDTH:0] c_last_byte = (ADDR_WIDTH+1)'(DEPTH*4-1);
  localparam logic [ADDR_WIDTH:0] c_word_tail = (ADDR_WIDTH+1)'(3);

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant;
  logic   [1:0] r_rsp_valid;
  logic   r_rsp_err;

  logic                    w_cand0;
  logic                    w_cand1;
  logic                    w_grant0;
  logic                    w_grant1;
  logic                    w_any;
  logic                    w_sel_write;
  logic                    w_sel_lock;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH/8-1:0] w_sel_be;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [ADDR_WIDTH:0]     w_end_addr;
  logic                    w_in_range;

  // Grant: a lock excludes the other requester; on conflict in OPEN the
  // requester that did not win last time gets the port. Nothing is granted
  // while reset is held.
  always_comb begin
    w_cand0  = req0_valid && (r_state != LOCK1) && !reset;
    w_cand1  = req1_valid && (r_state != LOCK0) && !reset;
    w_grant0 = w_cand0 && (!w_cand1 || r_last_grant);
    w_grant1 = w_cand1 && (!w_cand0 || !r_last_grant);
    w_any    = w_grant0 || w_grant1;
  end

  // Select the winning request's fields and range-check the full word.
  always_comb begin
    w_sel_write = w_grant1 ? req1_write       : req0_write;
    w_sel_lock  = w_grant1 ? req1_lock        : req0_lock;
    w_sel_addr  = w_grant1 ? req1_address     : req0_address;
    w_sel_be    = w_grant1 ? req1_byte_enable : req0_byte_enable;
    w_sel_wdata = w_grant1 ? req1_write_data  : req0_write_data;
    w_end_addr  = {1'b0, w_sel_addr} + c_word_tail;
    w_in_range  = (w_end_addr <= c_last_byte);
  end

  // Cache port: forward only in-range accepted accesses, otherwise all zero.
  always_comb begin
    mem_enable       = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_byte_enable  = '0;
    mem_write_data   = '0;
    if (w_any && w_in_range) begin
      mem_enable       = 1'b1;
      mem_write_enable = w_sel_write;
      mem_address      = w_sel_addr;
      mem_byte_enable  = w_sel_be;
      mem_write_data   = w_sel_wdata;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Arbitration state, round-robin history and one-cycle response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= OPEN;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 2'b00;
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      if (w_any) begin
        r_last_grant <= w_grant1;
        if (w_sel_lock) begin
          r_state <= w_grant1 ? LOCK1 : LOCK0;
        end else begin
          r_state <= OPEN;
        end
        if (!w_sel_write || !w_in_range) begin
          r_rsp_valid <= w_grant1 ? 2'b10 : 2'b01;
          r_rsp_err   <= !w_in_range;
        end
      end
    end
  end

  // Responses are suppressed while reset is held so a pending one is dropped.
  always_comb begin
    rsp0_valid     = r_rsp_valid[0] && !reset;
    rsp1_valid     = r_rsp_valid[1] && !reset;
    rsp0_error     = rsp0_valid && r_rsp_err;
    rsp1_error     = rsp1_valid && r_rsp_err;
    rsp0_read_data = (rsp0_valid && !r_rsp_err) ? mem_read_data : '0;
    rsp1_read_data = (rsp1_valid && !r_rsp_err) ? mem_read_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_dcache_arbiter                                           |
// | Purpose  : Self-checking bench for dcache_arbiter: vector table,       |
// |            directed corner sequences and random traffic against a      |
// |            behavioural model of the arbiter.                           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_dcache_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req0_lock;
  logic [31:0] req0_address, req0_write_data;
  logic [3:0]  req0_byte_enable;
  logic        req0_ready, rsp0_valid, rsp0_error;
  logic [31:0] rsp0_read_data;
  logic        req1_valid, req1_write, req1_lock;
  logic [31:0] req1_address, req1_write_data;
  logic [3:0]  req1_byte_enable;
  logic        req1_ready, rsp1_valid, rsp1_error;
  logic [31:0] rsp1_read_data;
  logic        mem_enable, mem_write_enable;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
    .req0_address(req0_address), .req0_byte_enable(req0_byte_enable),
    .req0_write_data(req0_write_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_error(rsp0_error), .rsp0_read_data(rsp0_read_data),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
    .req1_address(req1_address), .req1_byte_enable(req1_byte_enable),
    .req1_write_data(req1_write_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_error(rsp1_error), .rsp1_read_data(rsp1_read_data),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Cache stand-in: registered read, byte-lane writes.
  logic [31:0] cmem [16];
  always @(posedge clk) begin
    if (mem_enable) begin
      mem_read_data <= cmem[mem_address[5:2]];
      if (mem_write_enable)
        for (int k = 0; k < 4; k++)
          if (mem_byte_enable[k]) cmem[mem_address[5:2]][8*k +: 8] <= mem_write_data[8*k +: 8];
    end
  end

  // ---------------- behavioural model ----------------
  int          m_owner;      // -1 = nobody holds the lock
  int          m_last;       // requester granted most recently
  bit          m_pend [2];
  bit          m_pend_err;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [16];
  bit          acc0, acc1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Compare DUT against the model for the current inputs, then advance model.
  task automatic model_check();
    int          win;
    bit          c0, c1, inr, wr, lk;
    logic [31:0] a, d;
    logic [3:0]  b;
    longint      last_byte;
    c0  = req0_valid && m_owner != 1 && !reset;
    c1  = req1_valid && m_owner != 0 && !reset;
    win = -1;
    if (c0 && c1)  win = (m_last == 1) ? 0 : 1;
    else if (c0)   win = 0;
    else if (c1)   win = 1;
    a  = (win == 1) ? req1_address     : req0_address;
    b  = (win == 1) ? req1_byte_enable : req0_byte_enable;
    d  = (win == 1) ? req1_write_data  : req0_write_data;
    wr = (win == 1) ? req1_write       : req0_write;
    lk = (win == 1) ? req1_lock        : req0_lock;
    last_byte = longint'(a) + 3;
    inr = (win >= 0) && (last_byte <= 63);

    chk("ready0", {31'b0, req0_ready}, {31'b0, win == 0});
    chk("ready1", {31'b0, req1_ready}, {31'b0, win == 1});
    chk("mem_enable", {31'b0, mem_enable}, {31'b0, inr});
    chk("mem_write_enable", {31'b0, mem_write_enable}, {31'b0, inr && wr});
    chk("mem_address", mem_address, inr ? a : 32'h0);
    chk("mem_byte_enable", {28'b0, mem_byte_enable}, inr ? {28'b0, b} : 32'h0);
    chk("mem_write_data", mem_write_data, inr ? d : 32'h0);
    chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_pend[0] && !reset});
    chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_pend[1] && !reset});
    chk("rsp0_error", {31'b0, rsp0_error}, {31'b0, m_pend[0] && m_pend_err && !reset});
    chk("rsp1_error", {31'b0, rsp1_error}, {31'b0, m_pend[1] && m_pend_err && !reset});
    chk("rsp0_read_data", rsp0_read_data, (m_pend[0] && !m_pend_err && !reset) ? m_pend_data : 32'h0);
    chk("rsp1_read_data", rsp1_read_data, (m_pend[1] && !m_pend_err && !reset) ? m_pend_data : 32'h0);

    acc0 = (win == 0);
    acc1 = (win == 1);
    m_pend[0] = 0; m_pend[1] = 0; m_pend_err = 0; m_pend_data = 0;
    if (reset) begin
      m_owner = -1;
      m_last  = 1;
    end else if (win >= 0) begin
      m_last  = win;
      m_owner = lk ? win : -1;
      if (!wr || !inr) begin
        m_pend[win] = 1;
        m_pend_err  = !inr;
        m_pend_data = inr ? ref_mem[(a / 4) % 16] : 32'h0;
      end
      if (wr && inr)
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[(a / 4) % 16][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input bit l0, input logic [31:0] a0,
                       input logic [3:0] b0, input logic [31:0] d0,
                       input bit v1, input bit w1, input bit l1, input logic [31:0] a1,
                       input logic [3:0] b1, input logic [31:0] d1);
    req0_valid = v0; req0_write = w0; req0_lock = l0; req0_address = a0;
    req0_byte_enable = b0; req0_write_data = d0;
    req1_valid = v1; req1_write = w1; req1_lock = l1; req1_address = a1;
    req1_byte_enable = b1; req1_write_data = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    finish_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit v0, w0, l0; logic [31:0] a0; logic [3:0] b0; logic [31:0] d0;
    bit v1, w1, l1; logic [31:0] a1; logic [3:0] b1; logic [31:0] d1;
    bit r0, r1, en, s0, s1, err;
  } vec_t;

  vec_t tab [11];

  function automatic vec_t mk(bit v0, bit w0, bit l0, logic [31:0] a0,
                              bit v1, bit w1, bit l1, logic [31:0] a1,
                              bit r0, bit r1, bit en, bit s0, bit s1, bit err);
    vec_t t;
    t.v0 = v0; t.w0 = w0; t.l0 = l0; t.a0 = a0; t.b0 = 4'hF; t.d0 = 32'h5555_0000 | a0;
    t.v1 = v1; t.w1 = w1; t.l1 = l1; t.a1 = a1; t.b1 = 4'hF; t.d1 = 32'h1122_3344;
    t.r0 = r0; t.r1 = r1; t.en = en; t.s0 = s0; t.s1 = s1; t.err = err;
    return t;
  endfunction

  int       hold_cnt;
  bit       rv0, rv1;

  initial begin
    // contention: alternating grants starting with requester 0
    tab[0]  = mk(1,0,0,0,  1,0,0,4,  1,0,1, 0,0,0);
    tab[1]  = mk(1,0,0,0,  1,0,0,4,  0,1,1, 1,0,0);
    tab[2]  = mk(1,0,0,0,  1,0,0,4,  1,0,1, 0,1,0);
    tab[3]  = mk(1,0,0,0,  1,0,0,4,  0,1,1, 1,0,0);
    // lock: requester 1 writes with lock, keeps the port, then releases
    tab[4]  = mk(0,0,0,0,  1,1,1,8,  0,1,1, 0,1,0);
    tab[5]  = mk(1,0,0,0,  1,0,1,8,  0,1,1, 0,0,0);
    tab[6]  = mk(1,0,0,0,  1,0,0,8,  0,1,1, 0,1,0);
    tab[7]  = mk(1,0,0,0,  1,0,0,4,  1,0,1, 0,1,0);
    // range boundary: 61 is out of range, 60 is the last valid word
    tab[8]  = mk(1,0,0,61, 0,0,0,0,  1,0,0, 1,0,0);
    tab[9]  = mk(1,1,0,60, 0,0,0,0,  1,0,1, 1,0,1);
    tab[10] = mk(0,0,0,0,  0,0,0,0,  0,0,0, 0,0,0);

    m_owner = -1; m_last = 1; m_pend[0] = 0; m_pend[1] = 0; m_pend_err = 0; m_pend_data = 0;
    for (int i = 0; i < 16; i++) begin
      cmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    cmem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
    reset = 1'b1;
    idle();
    finish_cycle();

    // reset with requests pending: nothing granted
    drive(1, 0, 0, 0, 4'hF, 0, 1, 0, 0, 4, 4'hF, 0);
    cycle();
    cycle();
    reset = 1'b0;

    // single reader
    drive(1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_ready0", {31'b0, req0_ready}, 32'd1);
    model_check();
    finish_cycle();
    idle();
    @(negedge clk);
    chk("single_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("single_rsp0_data", rsp0_read_data, 32'hDEAD_BEEF);
    chk("single_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    model_check();
    finish_cycle();

    // table vectors, starting from a fresh reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(tab[i].v0, tab[i].w0, tab[i].l0, tab[i].a0, tab[i].b0, tab[i].d0,
            tab[i].v1, tab[i].w1, tab[i].l1, tab[i].a1, tab[i].b1, tab[i].d1);
      @(negedge clk);
      chk($sformatf("tab%0d_ready0", i), {31'b0, req0_ready}, {31'b0, tab[i].r0});
      chk($sformatf("tab%0d_ready1", i), {31'b0, req1_ready}, {31'b0, tab[i].r1});
      chk($sformatf("tab%0d_mem_enable", i), {31'b0, mem_enable}, {31'b0, tab[i].en});
      chk($sformatf("tab%0d_rsp0_valid", i), {31'b0, rsp0_valid}, {31'b0, tab[i].s0});
      chk($sformatf("tab%0d_rsp1_valid", i), {31'b0, rsp1_valid}, {31'b0, tab[i].s1});
      chk($sformatf("tab%0d_rsp_error", i), {31'b0, rsp0_error | rsp1_error}, {31'b0, tab[i].err});
      model_check();
      finish_cycle();
    end

    // byte lanes: partial write then read back
    cmem[2] = 32'h0; ref_mem[2] = 32'h0;
    drive(1, 1, 0, 8, 4'b0101, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 8, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    idle();
    @(negedge clk);
    chk("lanes_rsp0_data", rsp0_read_data, 32'h00BB_00DD);
    model_check();
    finish_cycle();

    // reset mid-read: response dropped, arbiter back to OPEN with last_grant=1
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1, 4, 4'hF, 0);
    cycle();
    reset = 1'b1;
    drive(1, 0, 0, 0, 4'hF, 0, 1, 0, 0, 4, 4'hF, 0);
    @(negedge clk);
    chk("rstmid_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rstmid_ready1", {31'b0, req1_ready}, 32'd0);
    chk("rstmid_mem_enable", {31'b0, mem_enable}, 32'd0);
    model_check();
    finish_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_ready0_after", {31'b0, req0_ready}, 32'd1);
    chk("rstmid_ready1_after", {31'b0, req1_ready}, 32'd0);
    model_check();
    finish_cycle();

    // random traffic; requests are held unchanged until accepted
    rv0 = 0; rv1 = 0; acc0 = 0; acc1 = 0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!rv0 || acc0) begin
        rv0 = ($urandom_range(0, 2) != 0);
        req0_valid = rv0; req0_write = $urandom_range(0, 1); req0_lock = ($urandom_range(0, 3) == 0);
        req0_address = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                   : 32'($urandom_range(0, 66));
        req0_byte_enable = 4'($urandom); req0_write_data = $urandom;
      end
      if (!rv1 || acc1) begin
        rv1 = ($urandom_range(0, 2) != 0);
        req1_valid = rv1; req1_write = $urandom_range(0, 1); req1_lock = ($urandom_range(0, 3) == 0);
        req1_address = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                   : 32'($urandom_range(0, 66));
        req1_byte_enable = 4'($urandom); req1_write_data = $urandom;
      end
      cycle();
    end
    reset = 1'b0;
    idle();
    hold_cnt = 0;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
